// File: rtl/buffer_fifo_reader.sv
// buffer_fifo_reader
// Read-side controller for the 64x24 FIFO buffer memory. Works out occupancy
// from the writer's extended pointer and drives the memory read port. The
// memory's one-cycle registered read latency is absorbed by a two-entry output
// stage (head + skid), which feeds a valid/ready stream. The extended read
// pointer is exported so the write side can compute full/free space.
//
// Optional build macro: FIFO_OVF_DETECT_EN adds a sticky 'ovf' output. It is
// set when the computed level exceeds DEPTH, which means the writer overran
// the reader. Only reset clears it.
//
// Output-stage occupancy FSM:
//   state     | meaning
//   ----------+------------------------------------------------------
//   OCC_EMPTY | no word buffered, outvalid low
//   OCC_ONE   | head holds a word, skid free
//   OCC_TWO   | head and skid both hold words (skid is the newer word)

module buffer_fifo_reader #(
    parameter int DW = 24,
    parameter int AW = 6
) (
    input  logic          memclk,
    input  logic          reset,
    input  logic [AW:0]   wrptrfull,
    output logic [AW-1:0] rdptr,
    output logic          rden,
    input  logic [DW-1:0] rddata,
    output logic [AW:0]   rdptrfull,
    output logic [DW-1:0] outdata,
    output logic          outvalid,
    input  logic          outready,
    output logic [AW:0]   level,
    output logic          empty
`ifdef FIFO_OVF_DETECT_EN
    ,
    output logic          ovf
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e          state_q, state_d;
    logic [AW:0]   rdptrfull_q, rdptrfull_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] skid_q, skid_d;

    logic [1:0]    held;
    logic [2:0]    in_use;
    logic          pop;

    // Occupancy of the memory. The extended pointers wrap mod 2**(AW+1),
    // so this subtraction stays correct across the 127->0 rollover.
    always_comb begin
        level = wrptrfull - rdptrfull_q;
        empty = (level == '0);
    end

    // Stream handshake, and the read credit against the two output slots.
    // Any word already in flight needs a slot reserved for it. A pop in
    // this cycle frees a slot, so reading can continue at one word per cycle.
    always_comb begin
        held = 2'd0;
        case (state_q)
            OCC_ONE: held = 2'd1;
            OCC_TWO: held = 2'd2;
            default: held = 2'd0;
        endcase
        outvalid = (state_q != OCC_EMPTY);
        outdata  = head_q;
        pop      = outvalid & outready;
        in_use   = {1'b0, held} + {2'b00, inflight_q} - {2'b00, pop};
        rden     = (level != '0) && (in_use < 3'd2);
        rdptr    = rdptrfull_q[AW-1:0];
        rdptrfull = rdptrfull_q;
    end

    // Read pointer advance and in-flight tracking.
    always_comb begin
        rdptrfull_d = rdptrfull_q;
        inflight_d  = rden;
        if (rden) begin
            rdptrfull_d = rdptrfull_q + 1'b1;
        end
    end

    // Output-stage next state: load returning data and shift skid into head.
    // rddata counts only when inflight_q is set. The credit rule keeps
    // held + inflight <= 2, so a return never arrives while both slots are
    // full unless a pop happens in the same cycle.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            OCC_EMPTY: begin
                if (inflight_q) begin
                    head_d  = rddata;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({inflight_q, pop})
                    2'b10: begin
                        skid_d  = rddata;
                        state_d = OCC_TWO;
                    end
                    2'b11: begin
                        head_d = rddata;
                    end
                    2'b01: begin
                        state_d = OCC_EMPTY;
                    end
                    default: begin
                        state_d = OCC_ONE;
                    end
                endcase
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d = skid_q;
                    if (inflight_q) begin
                        skid_d = rddata;
                    end else begin
                        state_d = OCC_ONE;
                    end
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
    end

    // State and datapath registers. An async reset drops buffered words and
    // any read still in flight.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            state_q     <= OCC_EMPTY;
            rdptrfull_q <= '0;
            inflight_q  <= 1'b0;
            head_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            rdptrfull_q <= rdptrfull_d;
            inflight_q  <= inflight_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
        end
    end

`ifdef FIFO_OVF_DETECT_EN
    localparam logic [AW:0] DEPTH_PTR = (AW+1)'(2**AW);

    logic ovf_q, ovf_d;

    // Sticky overrun flag: once the level goes past DEPTH, it stays set.
    always_comb begin
        ovf_d = ovf_q | (level > DEPTH_PTR);
        ovf   = ovf_q;
    end

    // Overrun flag register.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: doc/buffer_fifo_reader.md
Name: buffer_fifo_reader

Overview:
Read-side controller for the 64x24 FIFO buffer memory. Tracks occupancy against the writer's extended pointer, drives the memory read port (rdptr/rden), absorbs the memory's 1-cycle registered read latency, and presents words on a valid/ready stream. Exports its extended read pointer so the write side can compute full/free space. Same clock domain as the writer and the memory (memclk).

Parameters:
DW, 24, data word width (matches memory word)
AW, 6, memory address width; DEPTH = 2**AW = 64 words

Ports:
memclk  input  1  clock; everything samples on rising edge
reset  input  1  asynchronous, active-high reset
wrptrfull  input  AW+1  writer's next-write pointer incl. wrap bit (low AW bits = memory address)
rdptr  output  AW  memory read address (low AW bits of rdptrfull)
rden  output  1  memory read enable
rddata  input  DW  memory read data, valid the cycle after rden
rdptrfull  output  AW+1  reader's next-read pointer incl. wrap bit, for writer full logic
outdata  output  DW  stream data
outvalid  output  1  stream valid
outready  input  1  stream ready from consumer
level  output  AW+1  words in memory not yet read (wrptrfull - rdptrfull, mod 2**(AW+1))
empty  output  1  level == 0

Behaviour:
- Reset (async assert, sync release): rdptrfull=0, rden=0, inflight=0, both output-stage entries invalid, outvalid=0, outdata=0, level=0, empty=1.
- level/empty combinational from pointers; 7-bit modular subtraction handles wrap (pointers roll 127->0). level range 0..64.
- Output stage: 2 entries (head drives outdata/outvalid, skid behind it). held = valid entries (0..2); inflight = 1 if rden issued last cycle.
- pop = outvalid & outready.
- rden = (level != 0) & (held + inflight - pop < 2); combinational. On rden: rdptrfull increments by 1 at the edge; inflight set for next cycle.
- Data return: cycle after rden, rddata is written into head if head empty or being popped without skid, else into skid. Never lost: credit rule above guarantees a free slot.
- Pop: head advances; skid moves into head same edge. Simultaneous pop + return with skid full: skid->head, return->skid.
- outdata/outvalid stable while outvalid & !outready (no data change while stalled).
- Latency: wrptrfull advance seen in cycle t -> rden in t -> outvalid in t+2 (empty stage). Sustained throughput 1 word/cycle with outready held high.
- Occupancy states by held: EMPTY(0), ONE(1), TWO(2); transitions +1 on return, -1 on pop, unchanged on both.
- rddata is ignored whenever inflight=0.
- Reset mid-operation: in-flight read discarded, buffered words dropped, pointers to 0; writer must reset together.
- level == 64 is legal (full); reader drains normally.

Optional Feature:
FIFO_OVF_DETECT_EN: when defined, adds output ovf (1 bit, reset 0): sticky-set when computed level > DEPTH (writer overran reader), cleared only by reset; reader behaviour otherwise unchanged. When undefined, the ovf port and logic are absent.

Test Plan:
- Reset: assert reset mid-stream with held=2, inflight=1 -> outvalid=0, rdptrfull=0, empty=1 immediately (async); no stale word after release.
- Single word: wrptrfull 0->1 at cycle t, outready=1 -> rden=1/rdptr=0 at t, outvalid=1 with outdata=mem[0] at t+2, empty=1 from t+1.
- Streaming: preload 64 words (wrptrfull=64), outready=1 -> 64 consecutive outvalid cycles, data mem[0..63] in order, rdptrfull ends 64, level 64->0.
- Backpressure: 10 words queued, outready=0 -> exactly 2 reads issued (rdptrfull=2), outdata=mem[0] held stable, level=8; release outready -> remaining words in order, no loss/duplication.
- Wrap: rdptrfull=wrptrfull=120, writer adds 16 -> level=16, rdptr wraps 63->0 at word 8, pointers end at 8 (mod 128), data order intact.
- With FIFO_OVF_DETECT_EN: wrptrfull=65 with rdptrfull=0 -> ovf=1 next cycle, stays 1 after level returns to 0 until reset.
